mac_seq: RTL and testbench

- Dot-product sequencer. It is the initiator side of the 16x16->40 multiply-accumulate datapath.
- Accepts a job (start + length), then streams operand pairs in over a valid/ready handshake.
- Drives the accumulator's x1/x2/en/rst pins and returns the final 40-bit sum over a valid/ready result port.
- Sits between the sample/coefficient source and the accumulator instance; it contains no arithmetic of its own.

---
 rtl/mac_seq.sv | 148 ++++++++++++++
 tb/tb_mac_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// mac_seq: dot-product sequencer, initiator side of a 16x16->40 multiply-accumulate datapath.
//
// Accepts a job (start + len), streams len operand pairs into an external accumulator
// over a valid/ready handshake, then returns the accumulator's final value on a
// valid/ready result port. This block does no arithmetic; it only sequences the
// accumulator's x1/x2/en/rst pins.
//
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   start, len        job request (sampled in idle only) and number of operand pairs
//   busy              high in every state except idle
//   in_valid, in_ready, in_a, in_b    operand-pair stream (in_ready only while running)
//   mac_x1, mac_x2, mac_en            registered operands / one-cycle accumulate enable
//   mac_rst           accumulator clear (reset or the clear state)
//   mac_y             accumulator output
//   out_valid, out_data, out_ready    result port; out_data held until accepted

module mac_seq #(
    parameter int unsigned N     = 16,
    parameter int unsigned ACC_W = 40,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             in_ready,
    output logic [N-1:0]     mac_x1,
    output logic [N-1:0]     mac_x2,
    output logic             mac_en,
    output logic             mac_rst,
    input  logic [ACC_W-1:0] mac_y,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    input  logic             out_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StCapture,
        StResult
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [N-1:0]     x1_q, x1_d;
    logic [N-1:0]     x2_q, x2_d;
    logic             en_q, en_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;

    logic in_hs;
    logic out_hs;

    assign in_ready = (state_q == StRun);
    assign busy     = (state_q != StIdle);
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid_q & out_ready;

    // Reset must clear the accumulator too, so a mid-job abort leaves no stale sum.
    assign mac_rst   = rst | (state_q == StClear);
    assign mac_x1    = x1_q;
    assign mac_x2    = x2_q;
    assign mac_en    = en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        en_d        = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = len;
                    state_d = StClear;
                end
            end
            StClear: begin
                // A zero-length job skips straight to capturing the (cleared) accumulator.
                state_d = (count_q != '0) ? StRun : StCapture;
            end
            StRun: begin
                if (in_hs) begin
                    x1_d    = in_a;
                    x2_d    = in_b;
                    en_d    = 1'b1;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The last pair's enable is live this cycle; the accumulator absorbs it
                // at the closing edge.
                state_d = StCapture;
            end
            StCapture: begin
                out_data_d  = mac_y;
                out_valid_d = 1'b1;
                state_d     = StResult;
            end
            StResult: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            en_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            en_q        <= en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: a behavioural accumulator sits on the mac_* pins,
// table vectors and random jobs are checked against sums computed directly from the
// operand lists, plus hand sequences for result hold and mid-job reset.

module tb_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_ready;
    logic [15:0] mac_x1;
    logic [15:0] mac_x2;
    logic        mac_en;
    logic        mac_rst;
    logic [39:0] mac_y;
    logic        out_valid;
    logic [39:0] out_data;
    logic        out_ready;

    always #5 clk = ~clk;

    mac_seq #(
        .N     (16),
        .ACC_W (40),
        .LEN_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .mac_x1    (mac_x1),
        .mac_x2    (mac_x2),
        .mac_en    (mac_en),
        .mac_rst   (mac_rst),
        .mac_y     (mac_y),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    // Behavioural accumulator: product sign-extended to 40 bits, wraps on overflow.
    logic signed [31:0] prod;
    assign prod = $signed(mac_x1) * $signed(mac_x2);
    always @(posedge clk) begin
        if (mac_rst) mac_y <= '0;
        else if (mac_en) mac_y <= mac_y + {{8{prod[31]}}, prod};
    end

    // Enable monitor: mac_en must follow exactly one cycle after each handshake.
    int cyc = 0;
    int en_cycles = 0;
    int en_bad = 0;
    bit hs_prev = 1'b0;
    bit mon_on = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_on) begin
            if (mac_en !== hs_prev) en_bad <= en_bad + 1;
            if (mac_en === 1'b1) en_cycles <= en_cycles + 1;
        end
        hs_prev <= rst ? 1'b0 : (in_valid & in_ready);
    end

    int passed = 0;
    int total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    logic signed [15:0] pa[256];
    logic signed [15:0] pb[256];

    function automatic logic [39:0] ref_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(pa[i]) * longint'(pb[i]);
        return s[39:0];
    endfunction

    // Runs one job from idle; mode 0 continuous valid, 1 toggling, 2 random.
    task automatic run_job(input int n, input int mode, input bit hold,
                           input logic [39:0] exp, input string name);
        int idx = 0;
        int bud = 0;
        int s_cyc;
        int hs_cyc;
        int en0;
        int bad0;
        bit tog = 1'b0;
        logic [39:0] held;
        @(negedge clk);
        start = 1'b1;
        len   = 8'(n);
        en0   = en_cycles;
        bad0  = en_bad;
        @(negedge clk);
        start  = 1'b0;
        s_cyc  = cyc;
        hs_cyc = s_cyc;
        check({name, "_clear"}, {61'd0, mac_rst, busy, in_ready}, 64'b110);
        while (idx < n && bud < 2000) begin
            tog = ~tog;
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = tog;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_a = in_valid ? pa[idx] : 16'($urandom);
            in_b = in_valid ? pb[idx] : 16'($urandom);
            if (in_valid && in_ready) begin
                idx++;
                hs_cyc = cyc + 1;
            end
            @(negedge clk);
            bud++;
        end
        in_valid = 1'b0;
        check({name, "_pairs"}, 64'(idx), 64'(n));
        bud = 0;
        while (out_valid !== 1'b1 && bud < 50) begin
            @(negedge clk);
            bud++;
        end
        check({name, "_latency"}, 64'(cyc - hs_cyc), 64'd2);
        check({name, "_data"}, 64'(out_data), 64'(exp));
        check({name, "_busy"}, 64'(busy), 64'd1);
        if (hold) begin
            held = out_data;
            for (int k = 0; k < 5; k++) begin
                start = (k % 2) == 0;
                len   = 8'd1;
                @(negedge clk);
                check({name, "_hold"}, {22'd0, out_valid, busy, out_data}, {22'd0, 2'b11, held});
            end
        end
        out_ready = 1'b1;
        start     = hold;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({name, "_accept"}, {62'd0, out_valid, busy}, 64'd0);
        check({name, "_en_count"}, 64'(en_cycles - en0), 64'(n));
        check({name, "_en_timing"}, 64'(en_bad - bad0), 64'd0);
    endtask

    typedef struct packed {
        logic [7:0]       len;
        logic [1:0]       mode;
        logic             hold;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [39:0]      exp;
    } vec_t;

    vec_t vecs[5];
    int idx_r;
    int bud_r;
    int n_r;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // a/b packed index 3 first: entries are {p3, p2, p1, p0}.
        vecs[0] = '{len: 8'd4, mode: 2'd0, hold: 1'b0,
                    a: {16'h0007, 16'hFFFB, 16'h0003, 16'h0001},
                    b: {16'hFFF8, 16'h0006, 16'h0004, 16'h0002},
                    exp: 40'hFFFFFFFFB8};
        vecs[1] = '{len: 8'd3, mode: 2'd1, hold: 1'b0,
                    a: {16'h0000, 16'h8000, 16'h8000, 16'h8000},
                    b: {16'h0000, 16'h8000, 16'h8000, 16'h8000},
                    exp: 40'h00C0000000};
        vecs[2] = '{len: 8'd0, mode: 2'd0, hold: 1'b0, a: '0, b: '0, exp: 40'h0};
        vecs[3] = '{len: 8'd2, mode: 2'd0, hold: 1'b1,
                    a: {16'h0000, 16'h0000, 16'h0001, 16'h0005},
                    b: {16'h0000, 16'h0000, 16'h0001, 16'h0005},
                    exp: 40'd26};
        vecs[4] = '{len: 8'd1, mode: 2'd0, hold: 1'b0,
                    a: {16'h0000, 16'h0000, 16'h0000, 16'h0002},
                    b: {16'h0000, 16'h0000, 16'h0000, 16'hFFFD},
                    exp: 40'hFFFFFFFFFA};

        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mac_rst", 64'(mac_rst), 64'd1);
        check("reset_ctrl", {60'd0, busy, in_ready, out_valid, mac_en}, 64'd0);
        check("reset_data", {24'd0, out_data}, 64'd0);
        check("reset_operands", {32'd0, mac_x1, mac_x2}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;
        check("idle_mac_rst", 64'(mac_rst), 64'd0);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                pa[j] = vecs[i].a[j];
                pb[j] = vecs[i].b[j];
            end
            run_job(int'(vecs[i].len), int'(vecs[i].mode), vecs[i].hold, vecs[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Reset after two of four pairs: abort with no result, then a clean job.
        @(negedge clk);
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start = 1'b0;
        idx_r = 0;
        bud_r = 0;
        while (idx_r < 2 && bud_r < 50) begin
            in_valid = 1'b1;
            in_a     = 16'd100;
            in_b     = 16'd100;
            if (in_ready) idx_r++;
            @(negedge clk);
            bud_r++;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("abort_mac_rst_during", 64'(mac_rst), 64'd1);
        @(negedge clk);
        check("abort_state", {60'd0, busy, in_ready, out_valid, mac_rst}, 64'b0001);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_result", {62'd0, out_valid, busy}, 64'd0);
        pa[0] = 16'sd3;
        pb[0] = 16'sd3;
        run_job(1, 0, 1'b0, 40'd9, "after_abort");

        // Largest job: 255 pairs of the most negative operand.
        for (int i = 0; i < 255; i++) begin
            pa[i] = 16'sh8000;
            pb[i] = 16'sh8000;
        end
        run_job(255, 0, 1'b0, 40'h3FC0000000, "len255");

        // Random jobs against the plain-arithmetic reference sum.
        for (int r = 0; r < 6; r++) begin
            n_r = $urandom_range(1, 24);
            for (int i = 0; i < n_r; i++) begin
                pa[i] = 16'($urandom);
                pb[i] = 16'($urandom);
            end
            run_job(n_r, $urandom_range(0, 2), 1'b0, ref_sum(n_r), $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
